// File: rtl/reg_scoreboard_pkg.sv
// Shared CPU register-file constants used by the scoreboard.
package reg_scoreboard_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register in-flight write counters gating decode issue.
// Optional SB_PERF_EN adds a saturating stall-cycle counter output.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic                 issue_we,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [REG_IDX_W-1:0] issue_rs1,
    input  logic [REG_IDX_W-1:0] issue_rs2,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic                 flush,
    output logic                 stall,
    output logic [NUM_REGS-1:0]  busy_mask,
`ifdef SB_PERF_EN
    output logic [31:0]          stall_cycles,
`endif
    output logic                 err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NUM_REGS];

    logic src_busy;
    logic dst_sat;
    logic accept;
    logic inc;
    logic dec;
    logic underflow_hit;

    // Hazard detection sees only registered counters; writeback lands after the edge.
    always_comb begin
        src_busy = ((issue_rs1 != REG_ZERO) && (cnt[issue_rs1] != '0)) ||
                   ((issue_rs2 != REG_ZERO) && (cnt[issue_rs2] != '0));
        dst_sat  = issue_we && (issue_rd != REG_ZERO) && (cnt[issue_rd] == CNT_MAX);
        stall    = issue_valid && !flush && (src_busy || dst_sat);
        accept   = issue_valid && !stall && !flush;
        inc      = accept && issue_we && (issue_rd != REG_ZERO);
        dec      = !flush && wb_valid && (wb_rd != REG_ZERO) && (cnt[wb_rd] != '0);
        underflow_hit = !flush && wb_valid && (wb_rd != REG_ZERO) && (cnt[wb_rd] == '0);
    end

    // Counter update; simultaneous inc and dec on one register cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((i == 0) || flush) begin
                    cnt[i] <= '0;
                end else if (inc && (issue_rd == reg_idx_t'(i)) &&
                             !(dec && (wb_rd == reg_idx_t'(i)))) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (dec && (wb_rd == reg_idx_t'(i)) &&
                             !(inc && (issue_rd == reg_idx_t'(i)))) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            busy_mask[i] = (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underflow <= 1'b0;
        end else if (underflow_hit) begin
            err_underflow <= 1'b1;
        end
    end

`ifdef SB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (flush) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table plus randomized run against a counter model.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    localparam int unsigned CNT_W = 2;
    localparam int CAP = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0, issue_we = 1'b0;
    logic [4:0]  issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] busy_mask;
    logic        err_underflow;
`ifdef SB_PERF_EN
    logic [31:0] stall_cycles;
    int unsigned m_perf;
`endif

    always #5 clk = ~clk;

    reg_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .stall(stall), .busy_mask(busy_mask),
`ifdef SB_PERF_EN
        .stall_cycles(stall_cycles),
`endif
        .err_underflow(err_underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_cnt [32];
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_stall(bit iv, bit we, logic [4:0] rd, logic [4:0] rs1,
                                   logic [4:0] rs2, bit fl);
        if (!iv || fl) return 1'b0;
        if (rs1 != 0 && m_cnt[rs1] > 0) return 1'b1;
        if (rs2 != 0 && m_cnt[rs2] > 0) return 1'b1;
        if (we && rd != 0 && m_cnt[rd] == CAP) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] > 0);
        return b;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err = 1'b0;
`ifdef SB_PERF_EN
        m_perf = 0;
`endif
    endtask

    // One clock of stimulus; compares at negedge, then advances the model at posedge.
    task automatic step(input bit iv, input bit we, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input bit wv, input logic [4:0] wrd, input bit fl,
                        input bit use_tab, input bit exp_st, input logic [31:0] exp_busy,
                        input bit exp_err, input string tag);
        bit s;
        issue_valid = iv; issue_we = we; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
        wb_valid = wv; wb_rd = wrd; flush = fl;
        @(negedge clk);
        s = m_stall(iv, we, rd, rs1, rs2, fl);
        if (use_tab) begin
            chk({tag, ".stall"}, 32'(stall), 32'(exp_st));
            chk({tag, ".busy"},  busy_mask, exp_busy);
            chk({tag, ".err"},   32'(err_underflow), 32'(exp_err));
        end else begin
            chk({tag, ".stall"}, 32'(stall), 32'(s));
            chk({tag, ".busy"},  busy_mask, m_busy());
            chk({tag, ".err"},   32'(err_underflow), 32'(m_err));
        end
`ifdef SB_PERF_EN
        chk({tag, ".perf"}, stall_cycles, m_perf);
`endif
        @(posedge clk);
        if (fl) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
`ifdef SB_PERF_EN
            m_perf = 0;
`endif
        end else begin
            int old_wb = m_cnt[wrd];
            if (iv && !s && we && rd != 0) m_cnt[rd]++;
            if (wv && wrd != 0) begin
                if (old_wb == 0) m_err = 1'b1;
                else m_cnt[wrd]--;
            end
`ifdef SB_PERF_EN
            if (s && m_perf != 32'hFFFF_FFFF) m_perf++;
`endif
        end
        #1;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset(input string tag);
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd10; issue_rs1 = 5'd10; issue_rs2 = 5'd5;
        wb_valid = 1'b0; flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk({tag, ".busy"},  busy_mask, 32'h0);
        chk({tag, ".err"},   32'(err_underflow), 32'h0);
        chk({tag, ".stall"}, 32'(stall), 32'h0);
        m_clear();
        issue_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        bit iv; bit we; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
        bit wv; logic [4:0] wrd; bit fl;
        bit st; logic [31:0] busy; bit err;
    } vec_t;

    function automatic vec_t mk(bit iv, bit we, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                bit wv, logic [4:0] wrd, bit fl, bit st, logic [31:0] busy, bit err);
        vec_t v;
        v.iv = iv; v.we = we; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.wv = wv; v.wrd = wrd; v.fl = fl; v.st = st; v.busy = busy; v.err = err;
        return v;
    endfunction

    vec_t tab [25];

    initial begin
        //            iv we rd  rs1 rs2 wv wrd fl  st  busy           err
        tab[0]  = mk(1, 1, 5,  0,  0,  0, 0,  0,  0, 32'h0000_0000, 0);
        tab[1]  = mk(1, 0, 0,  5,  0,  0, 0,  0,  1, 32'h0000_0020, 0);
        tab[2]  = mk(1, 0, 0,  5,  0,  1, 5,  0,  1, 32'h0000_0020, 0);
        tab[3]  = mk(1, 0, 0,  5,  0,  0, 0,  0,  0, 32'h0000_0000, 0);
        tab[4]  = mk(1, 1, 0,  0,  0,  0, 0,  0,  0, 32'h0000_0000, 0);
        tab[5]  = mk(1, 0, 0,  0,  0,  0, 0,  0,  0, 32'h0000_0000, 0);
        tab[6]  = mk(1, 1, 7,  0,  0,  0, 0,  0,  0, 32'h0000_0000, 0);
        tab[7]  = mk(1, 1, 7,  0,  0,  0, 0,  0,  0, 32'h0000_0080, 0);
        tab[8]  = mk(1, 1, 7,  0,  0,  0, 0,  0,  0, 32'h0000_0080, 0);
        tab[9]  = mk(1, 1, 7,  0,  0,  0, 0,  0,  1, 32'h0000_0080, 0);
        tab[10] = mk(1, 1, 7,  0,  0,  1, 7,  0,  1, 32'h0000_0080, 0);
        tab[11] = mk(1, 1, 7,  0,  0,  0, 0,  0,  0, 32'h0000_0080, 0);
        tab[12] = mk(0, 0, 0,  0,  0,  1, 7,  0,  0, 32'h0000_0080, 0);
        tab[13] = mk(0, 0, 0,  0,  0,  1, 7,  0,  0, 32'h0000_0080, 0);
        tab[14] = mk(0, 0, 0,  0,  0,  1, 7,  0,  0, 32'h0000_0080, 0);
        tab[15] = mk(1, 1, 9,  0,  0,  0, 0,  0,  0, 32'h0000_0000, 0);
        tab[16] = mk(1, 1, 9,  0,  0,  1, 9,  0,  0, 32'h0000_0200, 0);
        tab[17] = mk(0, 0, 0,  0,  0,  0, 0,  0,  0, 32'h0000_0200, 0);
        tab[18] = mk(0, 0, 0,  0,  0,  1, 9,  0,  0, 32'h0000_0200, 0);
        tab[19] = mk(0, 0, 0,  0,  0,  1, 3,  0,  0, 32'h0000_0000, 0);
        tab[20] = mk(0, 0, 0,  0,  0,  0, 0,  0,  0, 32'h0000_0000, 1);
        tab[21] = mk(1, 1, 2,  0,  0,  0, 0,  0,  0, 32'h0000_0000, 1);
        tab[22] = mk(1, 1, 4,  0,  0,  0, 0,  0,  0, 32'h0000_0004, 1);
        tab[23] = mk(1, 1, 6,  2,  0,  0, 0,  1,  0, 32'h0000_0014, 1);
        tab[24] = mk(0, 0, 0,  0,  0,  0, 0,  0,  0, 32'h0000_0000, 1);

        m_clear();
        #1;
        chk("reset.busy",  busy_mask, 32'h0);
        chk("reset.err",   32'(err_underflow), 32'h0);
        chk("reset.stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 25; k++) begin
            step(tab[k].iv, tab[k].we, tab[k].rd, tab[k].rs1, tab[k].rs2,
                 tab[k].wv, tab[k].wrd, tab[k].fl, 1'b1, tab[k].st, tab[k].busy, tab[k].err,
                 $sformatf("vec%0d", k));
        end

        // Build pending state and a sticky error, then reset asynchronously.
        step(1, 1, 10, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0, "pre_rst");
        step(1, 0, 0, 10, 0, 0, 0, 0, 1'b0, 0, 0, 0, "pre_rst2");
        do_reset("midrst");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 0, 32'h0, 0, "post_rst");

        for (int c = 0; c < 600; c++) begin
            bit fl;
            logic [4:0] wrd;
            fl  = ($urandom_range(0, 31) == 0);
            wrd = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
                 $urandom_range(0, 2) == 0, wrd, fl, 1'b0, 0, 0, 0, $sformatf("rnd%0d", c));
            if ((c % 150) == 149) do_reset($sformatf("rndrst%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
